// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding and an alignment helper.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Architectural PC owner: fetches one instruction at a time over req/gnt/rvalid,
// holds it for the core until retire, then loads the BCU next-PC (trapping misaligned targets).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic [31:0] pc_next,
  input  logic        halt,
  output logic        halted,
  output logic        misalign_trap,
  output logic [31:0] retire_count
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic        misalign_trap_q, misalign_trap_d;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    retire_count_d  = retire_count_q;
    misalign_trap_d = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // halt is only honoured here so an in-flight fetch always retires first
        if (instr_ready) begin
          retire_count_d = retire_count_q + 32'd1;
          if (is_word_aligned(pc_next)) begin
            pc_d = pc_next;
          end else begin
            pc_d            = TRAP_VECTOR;
            misalign_trap_d = 1'b1;
          end
          state_d = halt ? HALT : FETCH;
        end
      end
      HALT: begin
        if (!halt) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FETCH;
      pc_q            <= RESET_VECTOR;
      instr_q         <= 32'd0;
      retire_count_q  <= 32'd0;
      misalign_trap_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      retire_count_q  <= retire_count_d;
      misalign_trap_q <= misalign_trap_d;
    end
  end

  // Handshake outputs decode from the state register alone, keeping core inputs off every output path.
  assign imem_req      = (state_q == FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid   = (state_q == ISSUE);
  assign halted        = (state_q == HALT);
  assign instr         = instr_q;
  assign instr_pc      = pc_q;
  assign misalign_trap = misalign_trap_q;
  assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized fetch/retire traffic
// checked against a transaction-level model of PC, retire count and trap pulse.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] pc_next = 32'd0;
  logic        halt = 1'b0;
  logic        halted;
  logic        misalign_trap;
  logic [31:0] retire_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the architecture should look like right now.
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic [31:0] m_instr;
  logic        m_trap;

  pc_sequencer #(
    .RESET_VECTOR(RESET_VEC),
    .TRAP_VECTOR (TRAP_VEC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .pc_next      (pc_next),
    .halt         (halt),
    .halted       (halted),
    .misalign_trap(misalign_trap),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic ready, input logic [31:0] nxt);
    imem_gnt    = gnt;
    imem_rvalid = rvalid;
    imem_rdata  = rdata;
    instr_ready = ready;
    pc_next     = nxt;
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge. A trap pulse lasts one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    m_trap = 1'b0;
  endtask

  task automatic check_fetching(input string tag);
    checkOutput({tag, "_req"}, imem_req, 1'b1);
    checkOutput({tag, "_addr"}, imem_addr, m_pc);
    checkOutput({tag, "_ivalid"}, instr_valid, 1'b0);
    checkOutput({tag, "_halted"}, halted, 1'b0);
    checkOutput({tag, "_trap"}, misalign_trap, m_trap);
    checkOutput({tag, "_count"}, retire_count, m_count);
  endtask

  // One fetch transaction: gnt_delay stalled request cycles, then rsp_delay idle WAIT cycles.
  // Junk rvalid pulses are driven while requesting; they must be ignored.
  task automatic do_fetch(input int gnt_delay, input int rsp_delay, input logic [31:0] data);
    for (int i = 0; i < gnt_delay; i++) begin
      check_fetching("fetch_stall");
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0, 32'd0);
      tick();
    end
    check_fetching("fetch_gnt");
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b0, 32'd0);
    tick();
    for (int j = 0; j <= rsp_delay; j++) begin
      checkOutput("wait_req", imem_req, 1'b0);
      checkOutput("wait_ivalid", instr_valid, 1'b0);
      checkOutput("wait_trap", misalign_trap, m_trap);
      applyStimulus(1'b0, (j == rsp_delay), (j == rsp_delay) ? data : $urandom, 1'b0, 32'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    m_instr = data;
    checkOutput("issue_valid", instr_valid, 1'b1);
    checkOutput("issue_instr", instr, m_instr);
    checkOutput("issue_pc", instr_pc, m_pc);
    checkOutput("issue_req", imem_req, 1'b0);
  endtask

  // Hold the instruction for `stall` cycles, then retire it with the given next PC and halt.
  task automatic do_retire(input int stall, input logic [31:0] nxt, input logic h);
    for (int s = 0; s < stall; s++) begin
      checkOutput("bp_valid", instr_valid, 1'b1);
      checkOutput("bp_instr", instr, m_instr);
      checkOutput("bp_pc", instr_pc, m_pc);
      checkOutput("bp_count", retire_count, m_count);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, $urandom);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, nxt);
    halt = h;
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    m_count = m_count + 32'd1;
    if (nxt % 4 != 0) begin
      m_pc   = TRAP_VEC;
      m_trap = 1'b1;
    end else begin
      m_pc = nxt;
    end
    checkOutput("retire_count", retire_count, m_count);
    checkOutput("retire_trap", misalign_trap, m_trap);
    checkOutput("retire_ivalid", instr_valid, 1'b0);
    if (h) begin
      checkOutput("halt_halted", halted, 1'b1);
      checkOutput("halt_req", imem_req, 1'b0);
    end else begin
      checkOutput("retire_req", imem_req, 1'b1);
      checkOutput("retire_addr", imem_addr, m_pc);
    end
  endtask

  task automatic do_halt_release(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      checkOutput("halted_hold", halted, 1'b1);
      checkOutput("halted_req", imem_req, 1'b0);
      checkOutput("halted_ivalid", instr_valid, 1'b0);
      checkOutput("halted_trap", misalign_trap, m_trap);
      halt = 1'b1;
      tick();
    end
    halt = 1'b0;
    tick();
    check_fetching("resume");
  endtask

  initial begin
    logic [31:0] nxt;
    logic        h;
    int          kind;

    $display("[TB] pc_sequencer bench start");
    m_pc = RESET_VEC; m_count = 32'd0; m_instr = 32'd0; m_trap = 1'b0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_instr", instr, 32'd0);
    check_fetching("reset");

    // Zero-wait memory, sequential PCs 0x0, 0x4, 0x8
    for (int k = 0; k < 3; k++) begin
      checkOutput("seq_addr", imem_addr, 32'(k * 4));
      do_fetch(0, 0, $urandom);
      do_retire(0, m_pc + 32'd4, 1'b0);
    end
    checkOutput("seq_count3", retire_count, 32'd3);

    // Stalled grant: request and address stay stable
    do_fetch(4, 0, $urandom);
    do_retire(0, m_pc + 32'd4, 1'b0);

    // Core backpressure
    do_fetch(0, 2, 32'h0050_0093);
    do_retire(5, m_pc + 32'd4, 1'b0);

    // Branch to 0x40, then misaligned 0x42 traps to 0x10
    do_fetch(1, 0, $urandom);
    do_retire(0, 32'h0000_0040, 1'b0);
    checkOutput("branch_addr", imem_addr, 32'h0000_0040);
    do_fetch(0, 1, $urandom);
    do_retire(0, 32'h0000_0042, 1'b0);
    checkOutput("trap_addr", imem_addr, 32'h0000_0010);
    checkOutput("trap_pulse", misalign_trap, 1'b1);
    tick();
    checkOutput("trap_once", misalign_trap, 1'b0);

    // Halt raised during the fetch; instruction still retires, then resumes at pc_next
    halt = 1'b1;
    do_fetch(0, 2, $urandom);
    do_retire(1, 32'h0000_0080, 1'b1);
    do_halt_release(3);
    checkOutput("resume_addr", imem_addr, 32'h0000_0080);

    // Trap and halt on the same retire
    do_fetch(0, 0, $urandom);
    do_retire(0, 32'h0000_0101, 1'b1);
    do_halt_release(1);
    checkOutput("trap_halt_addr", imem_addr, TRAP_VEC);

    // Reset while in WAIT, then a stale rvalid in FETCH
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pc = RESET_VEC; m_count = 32'd0;
    check_fetching("midreset");
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_fetching("stale_rvalid");
    do_fetch(1, 1, 32'h1234_5678);
    checkOutput("post_reset_instr", instr, 32'h1234_5678);
    do_retire(0, m_pc + 32'd4, 1'b0);

    // Randomized traffic: variable latencies, branches, self-loops, traps and halts
    for (int it = 0; it < 40; it++) begin
      halt = 1'($urandom_range(0, 1));
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1:    nxt = m_pc + 32'd4;
        2:       nxt = m_pc;
        3:       nxt = $urandom & 32'h0000_0FFC;
        default: nxt = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
      endcase
      h = ($urandom_range(0, 5) == 0);
      do_retire($urandom_range(0, 3), nxt, h);
      if (h) begin
        do_halt_release($urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
